// File: rtl/ps2_keyboard_receiver.sv
// rtl/ps2_keyboard_receiver.sv - PS/2 device-to-host frame receiver with prefix folding
// Optional partial-frame timeout abort: define PS2_TIMEOUT_EN.
module ps2_keyboard_receiver #(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic       iPS2_CLK,
    input  logic       iPS2_DATA,
    output logic [7:0] oScanCode,
    output logic       oValid,
    output logic       oBreak,
    output logic       oExtended,
    output logic       oFrameError
);

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

    logic [1:0]            clk_sync_q, dat_sync_q;
    logic [FILTER_LEN-1:0] clk_sh_q, dat_sh_q;
    logic                  clk_filt_q, dat_filt_q, clk_prev_q;
    state_t                state_q;
    logic [3:0]            bit_cnt_q;
    logic [7:0]            shift_q;
    logic                  parity_q;
    logic                  ext_pend_q, brk_pend_q;
    logic [7:0]            code_q;
    logic                  valid_q, brk_q, ext_q, ferr_q;
    logic                  sample_d;
    logic                  frame_ok_d;

    always_ff @(posedge Clock) begin
        if (Reset) begin
            clk_sync_q <= 2'b11;
            dat_sync_q <= 2'b11;
            clk_sh_q   <= '1;
            dat_sh_q   <= '1;
            clk_filt_q <= 1'b1;
            dat_filt_q <= 1'b1;
            clk_prev_q <= 1'b1;
        end else begin
            clk_sync_q <= {clk_sync_q[0], iPS2_CLK};
            dat_sync_q <= {dat_sync_q[0], iPS2_DATA};
            clk_sh_q   <= {clk_sh_q[FILTER_LEN-2:0], clk_sync_q[1]};
            dat_sh_q   <= {dat_sh_q[FILTER_LEN-2:0], dat_sync_q[1]};
            // Filtered line only moves on a unanimous window; anything mixed holds.
            if (&clk_sh_q)       clk_filt_q <= 1'b1;
            else if (~|clk_sh_q) clk_filt_q <= 1'b0;
            if (&dat_sh_q)       dat_filt_q <= 1'b1;
            else if (~|dat_sh_q) dat_filt_q <= 1'b0;
            clk_prev_q <= clk_filt_q;
        end
    end

    assign sample_d   = clk_prev_q & ~clk_filt_q;
    assign frame_ok_d = dat_filt_q & (^shift_q ^ parity_q);

`ifdef PS2_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TO_W-1:0] to_cnt_q;

    always_ff @(posedge Clock) begin
        if (Reset || sample_d || state_q == IDLE) to_cnt_q <= '0;
        else if (to_cnt_q != TO_W'(TIMEOUT_CYCLES)) to_cnt_q <= to_cnt_q + 1'b1;
    end
`endif

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q    <= IDLE;
            bit_cnt_q  <= 4'd0;
            shift_q    <= 8'h00;
            parity_q   <= 1'b0;
            ext_pend_q <= 1'b0;
            brk_pend_q <= 1'b0;
            code_q     <= 8'h00;
            valid_q    <= 1'b0;
            brk_q      <= 1'b0;
            ext_q      <= 1'b0;
            ferr_q     <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
            if (sample_d) begin
                case (state_q)
                    IDLE: begin
                        if (!dat_filt_q) begin
                            state_q   <= DATA;
                            bit_cnt_q <= 4'd0;
                        end
                    end
                    DATA: begin
                        shift_q   <= {dat_filt_q, shift_q[7:1]};
                        bit_cnt_q <= bit_cnt_q + 4'd1;
                        if (bit_cnt_q == 4'd7) state_q <= PARITY;
                    end
                    PARITY: begin
                        parity_q <= dat_filt_q;
                        state_q  <= STOP;
                    end
                    STOP: begin
                        state_q <= IDLE;
                        if (!frame_ok_d) begin
                            ferr_q     <= 1'b1;
                            ext_pend_q <= 1'b0;
                            brk_pend_q <= 1'b0;
                        end else if (shift_q == 8'hE0) begin
                            ext_pend_q <= 1'b1;
                        end else if (shift_q == 8'hF0) begin
                            brk_pend_q <= 1'b1;
                        end else begin
                            valid_q    <= 1'b1;
                            code_q     <= shift_q;
                            ext_q      <= ext_pend_q;
                            brk_q      <= brk_pend_q;
                            ext_pend_q <= 1'b0;
                            brk_pend_q <= 1'b0;
                        end
                    end
                    default: state_q <= IDLE;
                endcase
`ifdef PS2_TIMEOUT_EN
            end else if (state_q != IDLE && to_cnt_q == TO_W'(TIMEOUT_CYCLES)) begin
                state_q    <= IDLE;
                ferr_q     <= 1'b1;
                ext_pend_q <= 1'b0;
                brk_pend_q <= 1'b0;
`endif
            end
        end
    end

    assign oScanCode   = code_q;
    assign oValid      = valid_q;
    assign oBreak      = brk_q;
    assign oExtended   = ext_q;
    assign oFrameError = ferr_q;

endmodule

// File: tb/tb_ps2_keyboard_receiver.sv
// tb/tb_ps2_keyboard_receiver.sv - table-driven bench for ps2_keyboard_receiver
module tb_ps2_keyboard_receiver;

    localparam int H   = 20;
    localparam int LAT = 12;

    logic       Clock = 1'b0;
    logic       Reset = 1'b1;
    logic       iPS2_CLK = 1'b1;
    logic       iPS2_DATA = 1'b1;
    logic [7:0] oScanCode;
    logic       oValid, oBreak, oExtended, oFrameError;

    ps2_keyboard_receiver dut (
        .Clock      (Clock),
        .Reset      (Reset),
        .iPS2_CLK   (iPS2_CLK),
        .iPS2_DATA  (iPS2_DATA),
        .oScanCode  (oScanCode),
        .oValid     (oValid),
        .oBreak     (oBreak),
        .oExtended  (oExtended),
        .oFrameError(oFrameError)
    );

    always #10 Clock = ~Clock;

    int cyc = 0;
    always @(posedge Clock) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;
    int n_valid = 0, n_err = 0, n_viol = 0;
    int valid_cyc = 0, stop_cyc = 0;
    logic prev_valid = 1'b0, prev_err = 1'b0;

    always @(negedge Clock) begin
        if (oValid) begin
            n_valid++;
            valid_cyc = cyc;
        end
        if (oFrameError) n_err++;
        if ((oValid && oFrameError) || (oValid && prev_valid) || (oFrameError && prev_err))
            n_viol++;
        prev_valid = oValid;
        prev_err   = oFrameError;
    end

    typedef struct {
        logic [7:0] data;
        logic       bad_par;
        logic       bad_stop;
        int         exp_valid;
        int         exp_err;
        logic [7:0] exp_code;
        logic       exp_brk;
        logic       exp_ext;
    } vec_t;

    vec_t vecs[13];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic send_bit(input logic b, input logic is_stop);
        iPS2_DATA = b;
        repeat (H) @(negedge Clock);
        iPS2_CLK = 1'b0;
        if (is_stop) stop_cyc = cyc;
        repeat (H) @(negedge Clock);
        iPS2_CLK = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic bad_par, input logic bad_stop);
        send_bit(1'b0, 1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i], 1'b0);
        send_bit((~^d) ^ bad_par, 1'b0);
        send_bit(~bad_stop, 1'b1);
        iPS2_DATA = 1'b1;
        repeat (2 * H) @(negedge Clock);
    endtask

    task automatic clear_counts();
        n_valid = 0;
        n_err   = 0;
    endtask

    initial begin
        vecs[0]  = '{8'h1C, 1'b0, 1'b0, 1, 0, 8'h1C, 1'b0, 1'b0};
        vecs[1]  = '{8'hF0, 1'b0, 1'b0, 0, 0, 8'h1C, 1'b0, 1'b0};
        vecs[2]  = '{8'h1C, 1'b0, 1'b0, 1, 0, 8'h1C, 1'b1, 1'b0};
        vecs[3]  = '{8'h1C, 1'b0, 1'b0, 1, 0, 8'h1C, 1'b0, 1'b0};
        vecs[4]  = '{8'hE0, 1'b0, 1'b0, 0, 0, 8'h1C, 1'b0, 1'b0};
        vecs[5]  = '{8'hF0, 1'b0, 1'b0, 0, 0, 8'h1C, 1'b0, 1'b0};
        vecs[6]  = '{8'h75, 1'b0, 1'b0, 1, 0, 8'h75, 1'b1, 1'b1};
        vecs[7]  = '{8'hF0, 1'b0, 1'b0, 0, 0, 8'h75, 1'b1, 1'b1};
        vecs[8]  = '{8'h1C, 1'b1, 1'b0, 0, 1, 8'h75, 1'b1, 1'b1};
        vecs[9]  = '{8'h1C, 1'b0, 1'b0, 1, 0, 8'h1C, 1'b0, 1'b0};
        vecs[10] = '{8'h5A, 1'b0, 1'b1, 0, 1, 8'h1C, 1'b0, 1'b0};
        vecs[11] = '{8'hE0, 1'b0, 1'b0, 0, 0, 8'h1C, 1'b0, 1'b0};
        vecs[12] = '{8'h6B, 1'b0, 1'b0, 1, 0, 8'h6B, 1'b0, 1'b1};

        repeat (5) @(negedge Clock);
        Reset = 1'b0;
        repeat (3) @(negedge Clock);
        chk("reset_code", oScanCode, 8'h00);
        chk("reset_valid", oValid, 0);
        chk("reset_break", oBreak, 0);
        chk("reset_ext", oExtended, 0);
        chk("reset_ferr", oFrameError, 0);

        for (int v = 0; v < 13; v++) begin
            clear_counts();
            send_frame(vecs[v].data, vecs[v].bad_par, vecs[v].bad_stop);
            chk($sformatf("v%0d_valid_cnt", v), n_valid, vecs[v].exp_valid);
            chk($sformatf("v%0d_err_cnt", v), n_err, vecs[v].exp_err);
            chk($sformatf("v%0d_code", v), oScanCode, vecs[v].exp_code);
            chk($sformatf("v%0d_break", v), oBreak, vecs[v].exp_brk);
            chk($sformatf("v%0d_ext", v), oExtended, vecs[v].exp_ext);
            if (vecs[v].exp_valid == 1)
                chk($sformatf("v%0d_latency", v), valid_cyc - stop_cyc, LAT);
        end

        // Short low glitch on the idle clock line must not start anything.
        clear_counts();
        iPS2_CLK = 1'b0;
        repeat (3) @(negedge Clock);
        iPS2_CLK = 1'b1;
        repeat (40) @(negedge Clock);
        chk("glitch_valid_cnt", n_valid, 0);
        chk("glitch_err_cnt", n_err, 0);

        // Reset after four data bits discards the partial frame silently.
        send_bit(1'b0, 1'b0);
        send_bit(1'b1, 1'b0);
        send_bit(1'b0, 1'b0);
        send_bit(1'b0, 1'b0);
        send_bit(1'b1, 1'b0);
        iPS2_DATA = 1'b1;
        @(negedge Clock);
        Reset = 1'b1;
        repeat (3) @(negedge Clock);
        Reset = 1'b0;
        repeat (40) @(negedge Clock);
        chk("midreset_valid_cnt", n_valid, 0);
        chk("midreset_err_cnt", n_err, 0);
        chk("midreset_code", oScanCode, 8'h00);

        clear_counts();
        send_frame(8'h29, 1'b0, 1'b0);
        chk("after_reset_valid_cnt", n_valid, 1);
        chk("after_reset_err_cnt", n_err, 0);
        chk("after_reset_code", oScanCode, 8'h29);
        chk("after_reset_break", oBreak, 0);
        chk("after_reset_latency", valid_cyc - stop_cyc, LAT);

        chk("pulse_rule_violations", n_viol, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #5ms;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

endmodule
